// File: rtl/systolic_result_collector_if.sv
// ----------------------------------------------------------------------------
// systolic_result_collector_if
//   Bundles the two buses seen by the result collector:
//     * the per-PE result wavefront (pe_score / pe_dir / pe_valid), one lane
//       per PE, driven by the systolic array;
//     * the traceback buffer read port (rd_en / rd_row / rd_col in,
//       rd_dir / rd_valid out, one cycle of latency).
//   master : array + traceback-engine side (drives wavefront and read request)
//   slave  : collector side (receives wavefront, returns read data)
// ----------------------------------------------------------------------------
interface systolic_result_collector_if #(
  parameter int N       = 10,
  parameter int M       = 10,
  parameter int SCORE_W = 8
);
  // Lane i carries PE i; scores are two's-complement.
  logic [N-1:0][SCORE_W-1:0] pe_score;
  logic [N-1:0][1:0]         pe_dir;
  logic [N-1:0]              pe_valid;

  logic                      rd_en;
  logic [$clog2(N)-1:0]      rd_row;
  logic [$clog2(M)-1:0]      rd_col;
  logic [1:0]                rd_dir;
  logic                      rd_valid;

  modport master (
    output pe_score, pe_dir, pe_valid, rd_en, rd_row, rd_col,
    input  rd_dir, rd_valid
  );

  modport slave (
    input  pe_score, pe_dir, pe_valid, rd_en, rd_row, rd_col,
    output rd_dir, rd_valid
  );
endinterface

// File: rtl/systolic_result_collector.sv
// ----------------------------------------------------------------------------
// systolic_result_collector
//   Receiving end of the systolic array. Captures the direction of every cell
//   of one read-vs-ref pass into an N x M traceback buffer (one row per PE,
//   each row filled in arrival order by its own column counter), tracks the
//   best positive cell score with its position, and raises done once every
//   row holds M cells.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle pulse, clears state and begins a pass (wins over
//                 any pe_valid on the same edge)
//   res         : wavefront input + buffer read port (slave modport)
//   busy / done : collecting / full matrix captured (done held until start)
//   overflow    : sticky, a valid arrived that could not be accepted
//   max_score, max_row, max_col, max_found : best cell (earliest wins ties)
// ----------------------------------------------------------------------------
module systolic_result_collector #(
  parameter int N       = 10,
  parameter int M       = 10,
  parameter int SCORE_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  systolic_result_collector_if.slave  res,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic signed [SCORE_W-1:0]   max_score,
  output logic [$clog2(N)-1:0]        max_row,
  output logic [$clog2(M)-1:0]        max_col,
  output logic                        max_found
);

  localparam int RW    = $clog2(N);
  localparam int CW    = $clog2(M);
  localparam int CNT_W = $clog2(M + 1);
  localparam logic [CNT_W-1:0] M_CNT = CNT_W'(M);
  localparam logic [RW:0]      N_LIM = (RW + 1)'(N);
  localparam logic [CW:0]      M_LIM = (CW + 1)'(M);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           col_cnt_q [N];
  logic [CNT_W-1:0]           col_cnt_d [N];
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       overflow_q, overflow_d;
  logic signed [SCORE_W-1:0]  max_score_q, max_score_d;
  logic [RW-1:0]              max_row_q, max_row_d;
  logic [CW-1:0]              max_col_q, max_col_d;
  logic                       max_found_q, max_found_d;
  logic [N-1:0]               accept_s;
  logic                       all_full_s;
  logic [1:0]                 buf_q [N][M];
  logic [1:0]                 rd_dir_q, rd_dir_d;
  logic                       rd_valid_q, rd_valid_d;

  // Next-state, column counters, overflow and running maximum.
  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    max_score_d = max_score_q;
    max_row_d   = max_row_q;
    max_col_d   = max_col_q;
    max_found_d = max_found_q;
    accept_s    = '0;
    all_full_s  = 1'b1;

    if (start) begin
      // Fresh pass; any valid on this edge is deliberately discarded.
      state_d     = ST_COLLECT;
      busy_d      = 1'b1;
      done_d      = 1'b0;
      overflow_d  = 1'b0;
      max_score_d = '0;
      max_row_d   = '0;
      max_col_d   = '0;
      max_found_d = 1'b0;
      for (int i = 0; i < N; i++) begin
        col_cnt_d[i] = '0;
      end
    end else begin
      case (state_q)
        ST_COLLECT: begin
          for (int i = 0; i < N; i++) begin
            if (res.pe_valid[i] && (col_cnt_q[i] < M_CNT)) begin
              accept_s[i]  = 1'b1;
              col_cnt_d[i] = col_cnt_q[i] + CNT_W'(1);
            end else if (res.pe_valid[i]) begin
              overflow_d = 1'b1;
            end else begin
              accept_s[i] = 1'b0;
            end
          end
          // Ascending scan with a strict compare: equal scores never replace
          // the held value, so the lowest PE (and the earlier cell) wins.
          // Starting from the held max (>= 0) also filters non-positive scores.
          for (int i = 0; i < N; i++) begin
            if (accept_s[i] && ($signed(res.pe_score[i]) > max_score_d)) begin
              max_score_d = $signed(res.pe_score[i]);
              max_row_d   = RW'(i);
              max_col_d   = CW'(col_cnt_q[i]);
              max_found_d = 1'b1;
            end else begin
              max_found_d = max_found_d;
            end
          end
          for (int i = 0; i < N; i++) begin
            if (col_cnt_d[i] != M_CNT) begin
              all_full_s = 1'b0;
            end else begin
              all_full_s = all_full_s;
            end
          end
          if (all_full_s) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_COLLECT;
          end
        end
        ST_IDLE, ST_DONE: begin
          if (|res.pe_valid) begin
            overflow_d = 1'b1;
          end else begin
            overflow_d = overflow_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      max_score_q <= '0;
      max_row_q   <= '0;
      max_col_q   <= '0;
      max_found_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        col_cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      max_score_q <= max_score_d;
      max_row_q   <= max_row_d;
      max_col_q   <= max_col_d;
      max_found_q <= max_found_d;
      for (int i = 0; i < N; i++) begin
        col_cnt_q[i] <= col_cnt_d[i];
      end
    end
  end

  // Traceback buffer: each row has its own write port, so all PEs can land a
  // cell in the same cycle. Contents are not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (accept_s[i]) begin
        buf_q[i][CW'(col_cnt_q[i])] <= res.pe_dir[i];
      end
    end
  end

  // Read request decode; out-of-range coordinates answer 0 but still respond.
  always_comb begin
    rd_dir_d   = rd_dir_q;
    rd_valid_d = 1'b0;
    if (res.rd_en) begin
      rd_valid_d = 1'b1;
      if (({1'b0, res.rd_row} < N_LIM) && ({1'b0, res.rd_col} < M_LIM)) begin
        rd_dir_d = buf_q[res.rd_row][res.rd_col];
      end else begin
        rd_dir_d = 2'b00;
      end
    end else begin
      rd_valid_d = 1'b0;
    end
  end

  // Read data register (one-cycle latency).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dir_q   <= 2'b00;
      rd_valid_q <= 1'b0;
    end else begin
      rd_dir_q   <= rd_dir_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow     = overflow_q;
  assign max_score    = max_score_q;
  assign max_row      = max_row_q;
  assign max_col      = max_col_q;
  assign max_found    = max_found_q;
  assign res.rd_dir   = rd_dir_q;
  assign res.rd_valid = rd_valid_q;

endmodule
